// File: rtl/err_bit_saver_pkg.sv
// Shared widths, filler value, TP ids and FSM encoding for the Chase-mode
// error-bit saver.
package err_bit_saver_pkg;

    localparam int LOC_W   = 10;
    localparam int REL_W   = 7;
    localparam int MET_W   = REL_W + 3;
    localparam int NUM_TP  = 4;
    localparam int NUM_CS  = 4;
    localparam int MAX_SET = 6;

    localparam logic [LOC_W-1:0] NO_ERR_LOC = 10'd1023;

    localparam logic [2:0] TP1 = 3'd1;
    localparam logic [2:0] TP2 = 3'd2;
    localparam logic [2:0] TP3 = 3'd3;
    localparam logic [2:0] TP4 = 3'd4;

    typedef logic [MAX_SET-1:0][LOC_W-1:0] loc_set_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SELECT  = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // TP id minus one gives the flip set: bit0 = lrb0, bit1 = lrb1.
    function automatic logic [1:0] tp_flip(input logic [2:0] tp);
        return 2'(tp - 3'd1);
    endfunction

endpackage

// File: rtl/ebs_tp_merge.sv
// Combinational merge of one Chien result with a TP's flipped LRBs, plus the
// reliability metric of the merged set.
module ebs_tp_merge
    import err_bit_saver_pkg::*;
(
    input  logic                         fail,
    input  logic [2:0]                   num_err,
    input  logic [NUM_CS-1:0][LOC_W-1:0] cs_loc,
    input  logic [NUM_CS-1:0][REL_W-1:0] cs_rel,
    input  logic [1:0]                   flip,
    input  logic [LOC_W-1:0]             lrb_loc0,
    input  logic [LOC_W-1:0]             lrb_loc1,
    input  logic [REL_W-1:0]             lrb_rel0,
    input  logic [REL_W-1:0]             lrb_rel1,
    output loc_set_t                     set_loc,
    output logic [2:0]                   set_num,
    output logic [MET_W-1:0]             metric
);

    logic hit0;
    logic hit1;

    always_comb begin
        set_loc = {MAX_SET{NO_ERR_LOC}};
        set_num = '0;
        metric  = '0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (3'(i) < num_err) begin
                // A flipped LRB that Chien also reports cancels out of the set.
                if (flip[0] && !hit0 && cs_loc[i] == lrb_loc0) begin
                    hit0 = 1'b1;
                end else if (flip[1] && !hit1 && cs_loc[i] == lrb_loc1) begin
                    hit1 = 1'b1;
                end else begin
                    set_loc[set_num] = cs_loc[i];
                    set_num          = set_num + 3'd1;
                    metric           = metric + MET_W'(cs_rel[i]);
                end
            end
        end
        if (flip[0] && !hit0) begin
            set_loc[set_num] = lrb_loc0;
            set_num          = set_num + 3'd1;
            metric           = metric + MET_W'(lrb_rel0);
        end
        if (flip[1] && !hit1) begin
            set_loc[set_num] = lrb_loc1;
            set_num          = set_num + 3'd1;
            metric           = metric + MET_W'(lrb_rel1);
        end
        if (fail) begin
            set_loc = {MAX_SET{NO_ERR_LOC}};
            set_num = '0;
            metric  = '1;
        end
    end

endmodule

// File: rtl/err_bit_saver.sv
// Collects the four Chase test-pattern results, keeps their merged error sets
// and picks the lowest-metric TP once all four are in.
//
// state      | meaning
// COLLECT    | accept Chien results, wait for mask == 4'b1111
// SELECT     | compare stored metrics, register o_select_tp
// DONE       | pulse o_valid_pulse, clear mask, back to COLLECT
module err_bit_saver
    import err_bit_saver_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LOC_W-1:0] i_lrb_loc0,
    input  logic [LOC_W-1:0] i_lrb_loc1,
    input  logic [REL_W-1:0] i_lrb_rel0,
    input  logic [REL_W-1:0] i_lrb_rel1,
    input  logic             i_cs_valid,
    input  logic [2:0]       i_cs_tp,
    input  logic             i_cs_fail,
    input  logic [2:0]       i_cs_num_err,
    input  logic [LOC_W-1:0] i_cs_err_loc0,
    input  logic [LOC_W-1:0] i_cs_err_loc1,
    input  logic [LOC_W-1:0] i_cs_err_loc2,
    input  logic [LOC_W-1:0] i_cs_err_loc3,
    input  logic [REL_W-1:0] i_cs_rel0,
    input  logic [REL_W-1:0] i_cs_rel1,
    input  logic [REL_W-1:0] i_cs_rel2,
    input  logic [REL_W-1:0] i_cs_rel3,
    output logic [LOC_W-1:0] o_tp1_err_loc0,
    output logic [LOC_W-1:0] o_tp1_err_loc1,
    output logic [LOC_W-1:0] o_tp1_err_loc2,
    output logic [LOC_W-1:0] o_tp1_err_loc3,
    output logic [LOC_W-1:0] o_tp1_err_loc4,
    output logic [LOC_W-1:0] o_tp1_err_loc5,
    output logic [LOC_W-1:0] o_tp2_err_loc0,
    output logic [LOC_W-1:0] o_tp2_err_loc1,
    output logic [LOC_W-1:0] o_tp2_err_loc2,
    output logic [LOC_W-1:0] o_tp2_err_loc3,
    output logic [LOC_W-1:0] o_tp2_err_loc4,
    output logic [LOC_W-1:0] o_tp2_err_loc5,
    output logic [LOC_W-1:0] o_tp3_err_loc0,
    output logic [LOC_W-1:0] o_tp3_err_loc1,
    output logic [LOC_W-1:0] o_tp3_err_loc2,
    output logic [LOC_W-1:0] o_tp3_err_loc3,
    output logic [LOC_W-1:0] o_tp3_err_loc4,
    output logic [LOC_W-1:0] o_tp3_err_loc5,
    output logic [LOC_W-1:0] o_tp4_err_loc0,
    output logic [LOC_W-1:0] o_tp4_err_loc1,
    output logic [LOC_W-1:0] o_tp4_err_loc2,
    output logic [LOC_W-1:0] o_tp4_err_loc3,
    output logic [LOC_W-1:0] o_tp4_err_loc4,
    output logic [LOC_W-1:0] o_tp4_err_loc5,
    output logic [2:0]       o_tp1_num_err,
    output logic [2:0]       o_tp2_num_err,
    output logic [2:0]       o_tp3_num_err,
    output logic [2:0]       o_tp4_num_err,
    output logic [2:0]       o_select_tp,
    output logic             o_valid_pulse
);

    state_t            state;
    logic [NUM_TP-1:0] mask;
    loc_set_t          bank_loc [NUM_TP];
    logic [2:0]        bank_num [NUM_TP];
    logic [MET_W-1:0]  bank_met [NUM_TP];

    loc_set_t          m_loc;
    logic [2:0]        m_num;
    logic [MET_W-1:0]  m_met;
    logic              tp_ok;
    logic [1:0]        tp_idx;
    logic [1:0]        sel_idx;

    assign tp_ok  = i_cs_valid && (i_cs_tp >= TP1) && (i_cs_tp <= TP4);
    assign tp_idx = tp_flip(i_cs_tp);

    // Results arrive one TP at a time, so a single merge unit is shared.
    ebs_tp_merge u_merge (
        .fail     (i_cs_fail),
        .num_err  (i_cs_num_err),
        .cs_loc   ({i_cs_err_loc3, i_cs_err_loc2, i_cs_err_loc1, i_cs_err_loc0}),
        .cs_rel   ({i_cs_rel3, i_cs_rel2, i_cs_rel1, i_cs_rel0}),
        .flip     (tp_idx),
        .lrb_loc0 (i_lrb_loc0),
        .lrb_loc1 (i_lrb_loc1),
        .lrb_rel0 (i_lrb_rel0),
        .lrb_rel1 (i_lrb_rel1),
        .set_loc  (m_loc),
        .set_num  (m_num),
        .metric   (m_met)
    );

    // Strict less-than keeps the lower TP id on ties; all-failed lands on TP1.
    always_comb begin
        sel_idx = 2'd0;
        for (int k = 1; k < NUM_TP; k++) begin
            if (bank_met[k] < bank_met[sel_idx]) sel_idx = 2'(k);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_start) begin
            state         <= ST_COLLECT;
            mask          <= '0;
            o_select_tp   <= '0;
            o_valid_pulse <= 1'b0;
            for (int k = 0; k < NUM_TP; k++) begin
                bank_loc[k] <= {MAX_SET{NO_ERR_LOC}};
                bank_num[k] <= '0;
                bank_met[k] <= '1;
            end
        end else begin
            o_valid_pulse <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (tp_ok) begin
                        bank_loc[tp_idx] <= m_loc;
                        bank_num[tp_idx] <= m_num;
                        bank_met[tp_idx] <= m_met;
                        mask[tp_idx]     <= 1'b1;
                    end
                    if (mask == '1) state <= ST_SELECT;
                end
                ST_SELECT: begin
                    o_select_tp <= {1'b0, sel_idx} + 3'd1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    o_valid_pulse <= 1'b1;
                    mask          <= '0;
                    state         <= ST_COLLECT;
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    assign o_tp1_err_loc0 = bank_loc[0][0];
    assign o_tp1_err_loc1 = bank_loc[0][1];
    assign o_tp1_err_loc2 = bank_loc[0][2];
    assign o_tp1_err_loc3 = bank_loc[0][3];
    assign o_tp1_err_loc4 = bank_loc[0][4];
    assign o_tp1_err_loc5 = bank_loc[0][5];
    assign o_tp2_err_loc0 = bank_loc[1][0];
    assign o_tp2_err_loc1 = bank_loc[1][1];
    assign o_tp2_err_loc2 = bank_loc[1][2];
    assign o_tp2_err_loc3 = bank_loc[1][3];
    assign o_tp2_err_loc4 = bank_loc[1][4];
    assign o_tp2_err_loc5 = bank_loc[1][5];
    assign o_tp3_err_loc0 = bank_loc[2][0];
    assign o_tp3_err_loc1 = bank_loc[2][1];
    assign o_tp3_err_loc2 = bank_loc[2][2];
    assign o_tp3_err_loc3 = bank_loc[2][3];
    assign o_tp3_err_loc4 = bank_loc[2][4];
    assign o_tp3_err_loc5 = bank_loc[2][5];
    assign o_tp4_err_loc0 = bank_loc[3][0];
    assign o_tp4_err_loc1 = bank_loc[3][1];
    assign o_tp4_err_loc2 = bank_loc[3][2];
    assign o_tp4_err_loc3 = bank_loc[3][3];
    assign o_tp4_err_loc4 = bank_loc[3][4];
    assign o_tp4_err_loc5 = bank_loc[3][5];
    assign o_tp1_num_err  = bank_num[0];
    assign o_tp2_num_err  = bank_num[1];
    assign o_tp3_num_err  = bank_num[2];
    assign o_tp4_num_err  = bank_num[3];

endmodule

// File: doc/err_bit_saver.md
Name: err_bit_saver

Overview:
- Chase-mode (i_mode=1) result collector between the Chien search and the output selector.
- For each of 4 test patterns (TPs) it merges the Chien error locations with the TP's flipped least-reliable bits (LRBs) and computes a reliability metric.
- After all 4 TPs are in, it selects the minimum-metric TP and pulses valid to the output selector.
- The per-TP error sets are held stable until the next codeword starts.

Parameters:
- LOC_W, 10, error-location width; 1023 is the "no error" filler.
- REL_W, 7, unsigned reliability width per bit.
- MET_W, REL_W+3, metric width; holds the sum of 6 reliabilities without overflow.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  new codeword; clears the received mask and all stored TP results
- i_lrb_loc0, i_lrb_loc1  in  LOC_W each  positions of the two least reliable bits (distinct)
- i_lrb_rel0, i_lrb_rel1  in  REL_W each  reliabilities of those bits
- i_cs_valid  in  1  one Chien result present this cycle
- i_cs_tp  in  3  TP id 1..4 (tp1: no flip; tp2: flip lrb0; tp3: flip lrb1; tp4: flip both)
- i_cs_fail  in  1  decoding failure for this TP
- i_cs_num_err  in  3  Chien error count, 0..4
- i_cs_err_loc0..3  in  LOC_W each  Chien locations; only indices < num_err are meaningful
- i_cs_rel0..3  in  REL_W each  reliability of each Chien location
- o_tpK_err_loc0..5 (K=1..4)  out  LOC_W each  merged error set for TP K
- o_tpK_num_err (K=1..4)  out  3  merged count, 0..6
- o_select_tp  out  3  winning TP id, 1..4
- o_valid_pulse  out  1  one-cycle pulse: selection complete

Behaviour:
- Reset / i_start:
  - all o_tpK_err_locJ = 1023, o_tpK_num_err = 0, o_select_tp = 0, o_valid_pulse = 0;
  - received mask = 4'b0000; FSM goes to COLLECT.
  - If i_start and i_cs_valid arrive in the same cycle, i_start wins and the result is dropped.
- FSM states: COLLECT → SELECT → DONE → COLLECT.
  - COLLECT: on i_cs_valid with i_cs_tp in 1..4:
    - merge and register the TP's result in that cycle;
    - set the mask bit for that TP; a duplicate TP overwrites the earlier result;
    - i_cs_tp outside 1..4 is ignored.
    - When the mask becomes 4'b1111 (evaluated on the registered mask), go to SELECT.
  - SELECT (1 cycle): compare the 4 stored metrics and register o_select_tp.
  - DONE (1 cycle): o_valid_pulse = 1, then return to COLLECT with the mask cleared. Stored results are kept until the next i_start.
  - Latency: o_valid_pulse is high exactly 3 cycles after the edge capturing the 4th distinct TP.
  - i_cs_valid during SELECT or DONE is ignored.
- Merge for a TP whose flip set is F ⊆ {lrb0, lrb1}:
  - Chien location i is active if i < num_err.
  - An active location equal to a flipped LRB cancels: both are removed.
  - Each flipped LRB not cancelled is appended.
  - Output order: surviving Chien locations in index order, then lrb0 (if appended), then lrb1. Unused slots are 1023.
  - num_err = active − 2×cancelled + |F| − ... i.e. active − cancelled + (|F| − cancelled).
- Metric = sum of reliabilities of the final set: surviving Chien rel plus appended LRB rel, zero-extended to MET_W.
- Failed TP (i_cs_fail=1): stored num_err = 0, all locations = 1023, metric = all-ones.
- Selection:
  - Minimum metric wins; on a tie the lower TP id wins.
  - If all 4 TPs failed, o_select_tp = 1 (num_err 0 → downstream emits 1023).
- Arithmetic: all values unsigned; location comparisons use full LOC_W equality.

Decomposition:
- Shared package: LOC_W, REL_W, MET_W, NO_ERR_LOC = 1023, TP ids TP1..TP4, FSM state encoding.
- One sub-module, ebs_tp_merge: purely combinational merge + metric for one TP (inputs: Chien result, flip mask, LRBs). It is instantiated once, shared across TPs because they arrive serially, and its output is registered into the per-TP bank.

Test Plan:
- lrb=(100, 200), rel=(5, 9). TP1..4 each Chien {300} rel 20 → metrics 20/25/29/34; select_tp=1; tp4 set {300, 100, 200}, num_err 3; valid pulse 3 cycles after TP4.
- Cancellation: lrb=(100, 200); TP2 Chien {100, 50} rels (5, 3) → tp2 set {50}, num_err 1, metric 3. Other TPs have metric ≥ 10 → select_tp=2.
- Tie: TP3 and TP4 both metric 12, others failed → select_tp=3.
- All four fail → select_tp=1, every tp num_err 0, all locations 1023, one valid pulse.
- Out-of-order and duplicate: order 3, 1, 3, 2, 4, with the second TP3 differing → the second TP3 result is stored; a single pulse follows TP4.
- Reset mid-collection (after 2 TPs), then all 4 TPs → all outputs return to reset values; exactly one pulse, using only the post-reset data.
- i_start in the same cycle as i_cs_valid → result dropped and mask 0.
